nv_detector: RTL and testbench
==============================

# nv_detector

Parametrised successor to the single-channel NV threshold path. It takes the sample stream from the ADC controller, optionally averages it over 2^LOG_N samples, and compares the result against a manual threshold and a self-adjusting CFAR threshold. The CFAR threshold is stepped once per window to track a target exceedance count. It sits between the ADC controller (`sample`/`sample_valid`) and the stream outputs to the back end.

## Interface
Parameters:
- `DW`, 16: sample and threshold width (unsigned).
- `LOG_N`, 2: log2 of integration length. Used only with `NV_INTEG_EN`; must be ≥1.
- `WIN`, 1024: CFAR window length in detection events; range 1..65535.

Ports:
- `clk`  in  1: single clock.
- `reset`  in  1: asynchronous, active-high reset.
- `sample_valid`  in  1: one-cycle strobe, new sample (ADC done).
- `sample`  in  DW: ADC sample, unsigned.
- `thresh_manual`  in  DW: manual threshold; also the CFAR seed.
- `cfar_en`  in  1: level; CFAR adaptation runs while high.
- `cfar_pf`  in  16: target exceedances per window.
- `cfar_step`  in  DW: threshold adjustment per window.
- `det_valid`  out  1: one-cycle strobe, `streama`/`streamb` updated.
- `streama`  out  1: detection vs `thresh_manual`.
- `streamb`  out  1: detection vs `cfar_thresh`.
- `cfar_thresh`  out  DW: current CFAR threshold.
- `stat_cfar`  out  16: exceedance count of the last completed window.
- `cfar_update`  out  1: one-cycle strobe, window closed and threshold updated.

## Operation
- Reset: all outputs 0; `cfar_thresh`=0; FSM in IDLE; accumulators and counters 0.
- Detection value `x`:
  - Without integration, `x` = `sample` at each `sample_valid`.
  - With integration, see Configuration.
- Compare is strictly greater, unsigned: `streama` = x > `thresh_manual`; `streamb` = x > `cfar_thresh` (value before any same-cycle update).
- `streama`/`streamb` hold between events.
- CFAR FSM:
  - IDLE:
    - `cfar_thresh` is held; `streamb` still compares against it.
    - On `cfar_en`=1: load `cfar_thresh` ← `thresh_manual`, clear window counter `wc` and hit counter `hc`, go to RUN.
  - RUN:
    - Each detection event increments `wc`; `hc` also increments if the `streamb` compare is true.
    - When the event making `wc`=WIN occurs, go to UPDATE.
    - `cfar_en`=0 goes to IDLE and discards the partial window.
  - UPDATE (one cycle):
    - `stat_cfar` ← `hc` (including the final event).
    - If `hc` > `cfar_pf`: `cfar_thresh` += `cfar_step`, saturating at 2^DW−1.
    - If `hc` < `cfar_pf`: `cfar_thresh` −= `cfar_step`, saturating at 0.
    - If equal: threshold unchanged.
    - Pulse `cfar_update`; clear `wc`/`hc`.
    - Next state is RUN if `cfar_en`=1, else IDLE.
- A detection event arriving in the UPDATE cycle counts as event 1 of the new window and is compared against the pre-update threshold.
- `stat_cfar` is held across IDLE. It is not cleared on re-enable.

## Timing
- Without integration: `det_valid`, `streama` and `streamb` are registered one cycle after `sample_valid`.
- With integration: the same one-cycle latency applies after the 2^LOG_N-th sample; there is no `det_valid` for the other samples.
- `cfar_update` asserts the cycle after the WIN-th event's `det_valid`. The new `cfar_thresh` and `stat_cfar` are visible in the same cycle as `cfar_update`.
- `sample_valid` may be asserted every cycle. Back-to-back samples lose nothing.
- Asserting `reset` mid-window or mid-integration drops all partial state immediately.

## Configuration
- `NV_INTEG_EN` defined:
  - A DW+LOG_N-bit accumulator sums valid samples.
  - On the 2^LOG_N-th sample, `x` = (acc + sample) >> LOG_N (truncating mean) and acc clears.
  - The comparison and CFAR see one event per 2^LOG_N samples.
- `NV_INTEG_EN` undefined: no accumulator is built, every sample is an event, and `LOG_N` is ignored.

## Test plan
- Manual compare, no `NV_INTEG_EN`: `thresh_manual`=1000; samples 999, 1000, 1001 → `streama` 0, 0, 1, each 1 cycle after `sample_valid`.
- Integration, `NV_INTEG_EN`, LOG_N=2: samples 10, 20, 30, 41 → single `det_valid` with x=25; `thresh_manual`=24 → `streama`=1; no `det_valid` on the first three samples.
- CFAR up-step, WIN=8, `cfar_pf`=2, `cfar_step`=5, seed 100: 8 samples of 200 → `cfar_update` pulse, `stat_cfar`=8, `cfar_thresh`=105.
- Saturation: seed 3, step 5, all samples 0 → `cfar_thresh`=0 after the first window. Seed 2^DW−2, step 5, all samples max → 2^DW−1.
- Window boundary: event in the UPDATE cycle → counted in the new window (next `stat_cfar` reflects it) and compared against the old threshold.
- Reset mid-window: assert `reset` after 5 of 8 events → all outputs 0, FSM in IDLE. Re-enable → `cfar_thresh` = `thresh_manual`, and a full 8 events are needed for the next `cfar_update`.

Source files
------------

// File: rtl/nv_detector.sv
// NV threshold detector: manual and self-adjusting CFAR compare on the ADC sample stream.
// Define NV_INTEG_EN to average each 2^LOG_N samples into one detection event.
module nv_detector #(
  parameter int DW    = 16,
  parameter int LOG_N = 2,
  parameter int WIN   = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample,
  input  logic [DW-1:0] thresh_manual,
  input  logic          cfar_en,
  input  logic [15:0]   cfar_pf,
  input  logic [DW-1:0] cfar_step,
  output logic          det_valid,
  output logic          streama,
  output logic          streamb,
  output logic [DW-1:0] cfar_thresh,
  output logic [15:0]   stat_cfar,
  output logic          cfar_update
);

  localparam logic [15:0] WIN16 = 16'(WIN);

  if (LOG_N < 1) begin : g_log_n_chk
    $error("nv_detector: LOG_N must be >= 1");
  end
  if (WIN < 1 || WIN > 65535) begin : g_win_chk
    $error("nv_detector: WIN must be in 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic          w_evt;
  logic [DW-1:0] w_x;
  logic          w_hit_man;
  logic          w_hit_cfar;
  logic [15:0]   r_wc;
  logic [15:0]   r_hc;
  logic [15:0]   w_wc_inc;
  logic [15:0]   w_hc_inc;
  logic [DW-1:0] w_thresh_adj;

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DW] ? {DW{1'b1}} : s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a < b) ? '0 : (a - b);
  endfunction

`ifdef NV_INTEG_EN
  logic [DW+LOG_N-1:0] r_acc;
  logic [DW+LOG_N-1:0] w_sum;
  logic [LOG_N-1:0]    r_icnt;

  assign w_sum = r_acc + {{LOG_N{1'b0}}, sample};
  assign w_evt = sample_valid && (r_icnt == {LOG_N{1'b1}});
  assign w_x   = DW'(w_sum >> LOG_N);

  // Integration stage: accumulate until the 2^LOG_N-th sample, then restart
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc  <= '0;
      r_icnt <= '0;
    end else if (sample_valid) begin
      r_acc  <= w_evt ? '0 : w_sum;
      r_icnt <= r_icnt + 1'b1;
    end
  end
`else
  assign w_evt = sample_valid;
  assign w_x   = sample;
`endif

  assign w_hit_man  = w_x > thresh_manual;
  assign w_hit_cfar = w_x > cfar_thresh;
  assign w_wc_inc   = r_wc + 16'd1;
  assign w_hc_inc   = r_hc + {15'd0, w_hit_cfar};

  always_comb begin
    w_thresh_adj = cfar_thresh;
    if (r_hc > cfar_pf)
      w_thresh_adj = sat_add(cfar_thresh, cfar_step);
    else if (r_hc < cfar_pf)
      w_thresh_adj = sat_sub(cfar_thresh, cfar_step);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A window can close again straight out of UPDATE only when WIN is 1
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (cfar_en) w_state_nxt = S_RUN;
      S_RUN: begin
        if (!cfar_en)                        w_state_nxt = S_IDLE;
        else if (w_evt && w_wc_inc == WIN16) w_state_nxt = S_UPDATE;
      end
      S_UPDATE: begin
        if (!cfar_en)                    w_state_nxt = S_IDLE;
        else if (w_evt && WIN16 == 16'd1) w_state_nxt = S_UPDATE;
        else                             w_state_nxt = S_RUN;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output stage: compares use the threshold before any same-cycle update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_valid   <= 1'b0;
      streama     <= 1'b0;
      streamb     <= 1'b0;
      cfar_update <= 1'b0;
    end else begin
      det_valid   <= w_evt;
      cfar_update <= (r_state == S_UPDATE);
      if (w_evt) begin
        streama <= w_hit_man;
        streamb <= w_hit_cfar;
      end
    end
  end

  // CFAR stage: window counting and per-window threshold step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfar_thresh <= '0;
      stat_cfar   <= '0;
      r_wc        <= '0;
      r_hc        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cfar_en) begin
            cfar_thresh <= thresh_manual;
            r_wc        <= '0;
            r_hc        <= '0;
          end
        end
        S_RUN: begin
          if (!cfar_en) begin
            r_wc <= '0;
            r_hc <= '0;
          end else if (w_evt) begin
            r_wc <= w_wc_inc;
            r_hc <= w_hc_inc;
          end
        end
        S_UPDATE: begin
          stat_cfar   <= r_hc;
          cfar_thresh <= w_thresh_adj;
          r_wc        <= w_evt ? 16'd1 : 16'd0;
          r_hc        <= (w_evt && w_hit_cfar) ? 16'd1 : 16'd0;
        end
        default: begin
          r_wc <= '0;
          r_hc <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nv_detector.sv
// Directed self-checking bench for nv_detector (DW=16, WIN=8).
module tb_nv_detector;

  localparam int DW    = 16;
  localparam int LOG_N = 2;
  localparam int WIN   = 8;
`ifdef NV_INTEG_EN
  localparam int NSPE = 1 << LOG_N;
`else
  localparam int NSPE = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_valid;
  logic [DW-1:0] sample;
  logic [DW-1:0] thresh_manual;
  logic          cfar_en;
  logic [15:0]   cfar_pf;
  logic [DW-1:0] cfar_step;
  logic          det_valid;
  logic          streama;
  logic          streamb;
  logic [DW-1:0] cfar_thresh;
  logic [15:0]   stat_cfar;
  logic          cfar_update;

  int n_cmp = 0;
  int n_bad = 0;

  nv_detector #(.DW(DW), .LOG_N(LOG_N), .WIN(WIN)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample       (sample),
    .thresh_manual(thresh_manual),
    .cfar_en      (cfar_en),
    .cfar_pf      (cfar_pf),
    .cfar_step    (cfar_step),
    .det_valid    (det_valid),
    .streama      (streama),
    .streamb      (streamb),
    .cfar_thresh  (cfar_thresh),
    .stat_cfar    (stat_cfar),
    .cfar_update  (cfar_update)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at 1 time unit after a rising edge; consecutive calls are back-to-back
  task automatic send_sample(input logic [DW-1:0] v);
    sample       = v;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic send_event(input logic [DW-1:0] v);
    for (int i = 0; i < NSPE; i++) send_sample(v);
  endtask

  task automatic arm(input logic [DW-1:0] seed);
    cfar_en = 1'b0;
    tick();
    thresh_manual = seed;
    cfar_en       = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; sample_valid = 1'b0; sample = '0; thresh_manual = '0;
    cfar_en = 1'b0; cfar_pf = '0; cfar_step = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (det_valid !== 1'b0) begin n_bad++; $display("FAIL reset_det_valid got %0b want 0", det_valid); end
    n_cmp++; if (streama !== 1'b0) begin n_bad++; $display("FAIL reset_streama got %0b want 0", streama); end
    n_cmp++; if (streamb !== 1'b0) begin n_bad++; $display("FAIL reset_streamb got %0b want 0", streamb); end
    n_cmp++; if (cfar_thresh !== 16'd0) begin n_bad++; $display("FAIL reset_thresh got %0d want 0", cfar_thresh); end
    n_cmp++; if (stat_cfar !== 16'd0) begin n_bad++; $display("FAIL reset_stat got %0d want 0", stat_cfar); end
    n_cmp++; if (cfar_update !== 1'b0) begin n_bad++; $display("FAIL reset_update got %0b want 0", cfar_update); end
  endtask

`ifdef NV_INTEG_EN
  task automatic test_integ();
    logic [DW-1:0] vals [4];
    vals[0] = 16'd10; vals[1] = 16'd20; vals[2] = 16'd30; vals[3] = 16'd41;
    thresh_manual = 16'd24;
    for (int i = 0; i < 3; i++) begin
      send_sample(vals[i]);
      n_cmp++; if (det_valid !== 1'b0) begin n_bad++; $display("FAIL integ_no_det_%0d got %0b want 0", i, det_valid); end
    end
    send_sample(vals[3]);
    n_cmp++; if (det_valid !== 1'b1) begin n_bad++; $display("FAIL integ_det got %0b want 1", det_valid); end
    n_cmp++; if (streama !== 1'b1) begin n_bad++; $display("FAIL integ_streama got %0b want 1", streama); end
  endtask
`endif

  task automatic test_manual();
    thresh_manual = 16'd1000;
    cfar_en = 1'b0;
    send_event(16'd999);
    n_cmp++; if (det_valid !== 1'b1) begin n_bad++; $display("FAIL man_det_999 got %0b want 1", det_valid); end
    n_cmp++; if (streama !== 1'b0) begin n_bad++; $display("FAIL man_a_999 got %0b want 0", streama); end
    n_cmp++; if (streamb !== 1'b1) begin n_bad++; $display("FAIL man_b_999 got %0b want 1", streamb); end
    tick();
    n_cmp++; if (det_valid !== 1'b0) begin n_bad++; $display("FAIL man_det_gap got %0b want 0", det_valid); end
    send_event(16'd1000);
    n_cmp++; if (streama !== 1'b0) begin n_bad++; $display("FAIL man_a_1000 got %0b want 0", streama); end
    send_event(16'd1001);
    n_cmp++; if (streama !== 1'b1) begin n_bad++; $display("FAIL man_a_1001 got %0b want 1", streama); end
    tick();
    n_cmp++; if (streama !== 1'b1) begin n_bad++; $display("FAIL man_a_hold got %0b want 1", streama); end
  endtask

  task automatic test_cfar_up();
    cfar_pf = 16'd2; cfar_step = 16'd5;
    arm(16'd100);
    n_cmp++; if (cfar_thresh !== 16'd100) begin n_bad++; $display("FAIL up_seed got %0d want 100", cfar_thresh); end
    for (int i = 0; i < WIN; i++) send_event(16'd200);
    n_cmp++; if (cfar_update !== 1'b0) begin n_bad++; $display("FAIL up_early got %0b want 0", cfar_update); end
    tick();
    n_cmp++; if (cfar_update !== 1'b1) begin n_bad++; $display("FAIL up_pulse got %0b want 1", cfar_update); end
    n_cmp++; if (stat_cfar !== 16'd8) begin n_bad++; $display("FAIL up_stat got %0d want 8", stat_cfar); end
    n_cmp++; if (cfar_thresh !== 16'd105) begin n_bad++; $display("FAIL up_thresh got %0d want 105", cfar_thresh); end
    tick();
    n_cmp++; if (cfar_update !== 1'b0) begin n_bad++; $display("FAIL up_pulse_end got %0b want 0", cfar_update); end
  endtask

  task automatic test_saturation();
    cfar_pf = 16'd2; cfar_step = 16'd5;
    arm(16'd3);
    for (int i = 0; i < WIN; i++) send_event(16'd0);
    tick();
    n_cmp++; if (cfar_thresh !== 16'd0) begin n_bad++; $display("FAIL sat_low got %0d want 0", cfar_thresh); end
    n_cmp++; if (stat_cfar !== 16'd0) begin n_bad++; $display("FAIL sat_low_stat got %0d want 0", stat_cfar); end
    arm(16'hFFFE);
    for (int i = 0; i < WIN; i++) send_event(16'hFFFF);
    n_cmp++; if (streama !== 1'b1) begin n_bad++; $display("FAIL sat_max_a got %0b want 1", streama); end
    tick();
    n_cmp++; if (cfar_thresh !== 16'hFFFF) begin n_bad++; $display("FAIL sat_high got %0d want 65535", cfar_thresh); end
    n_cmp++; if (stat_cfar !== 16'd8) begin n_bad++; $display("FAIL sat_high_stat got %0d want 8", stat_cfar); end
  endtask

  task automatic test_equal();
    cfar_pf = 16'd3; cfar_step = 16'd5;
    arm(16'd50);
    for (int i = 0; i < 3; i++) send_event(16'd100);
    for (int i = 0; i < 5; i++) send_event(16'd10);
    tick();
    n_cmp++; if (cfar_update !== 1'b1) begin n_bad++; $display("FAIL eq_pulse got %0b want 1", cfar_update); end
    n_cmp++; if (stat_cfar !== 16'd3) begin n_bad++; $display("FAIL eq_stat got %0d want 3", stat_cfar); end
    n_cmp++; if (cfar_thresh !== 16'd50) begin n_bad++; $display("FAIL eq_thresh got %0d want 50", cfar_thresh); end
  endtask

`ifndef NV_INTEG_EN
  task automatic test_back_to_back();
    cfar_pf = 16'd2; cfar_step = 16'd5;
    arm(16'd100);
    for (int i = 0; i < WIN; i++) send_event(16'd200);
    // This event lands in the UPDATE cycle: 103 beats the old 100 but not the new 105
    send_event(16'd103);
    n_cmp++; if (streamb !== 1'b1) begin n_bad++; $display("FAIL b2b_old_thresh got %0b want 1", streamb); end
    n_cmp++; if (cfar_update !== 1'b1) begin n_bad++; $display("FAIL b2b_pulse got %0b want 1", cfar_update); end
    n_cmp++; if (cfar_thresh !== 16'd105) begin n_bad++; $display("FAIL b2b_thresh1 got %0d want 105", cfar_thresh); end
    for (int i = 0; i < WIN - 1; i++) send_event(16'd103);
    n_cmp++; if (streamb !== 1'b0) begin n_bad++; $display("FAIL b2b_new_thresh got %0b want 0", streamb); end
    tick();
    n_cmp++; if (cfar_update !== 1'b1) begin n_bad++; $display("FAIL b2b_pulse2 got %0b want 1", cfar_update); end
    n_cmp++; if (stat_cfar !== 16'd1) begin n_bad++; $display("FAIL b2b_stat got %0d want 1", stat_cfar); end
    n_cmp++; if (cfar_thresh !== 16'd100) begin n_bad++; $display("FAIL b2b_thresh2 got %0d want 100", cfar_thresh); end
  endtask
`endif

  task automatic test_reset_mid();
    cfar_pf = 16'd2; cfar_step = 16'd5;
    arm(16'd100);
    for (int i = 0; i < 5; i++) send_event(16'd200);
    reset = 1'b1;
    cfar_en = 1'b0;
    #2;
    n_cmp++; if (det_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_det got %0b want 0", det_valid); end
    n_cmp++; if (streamb !== 1'b0) begin n_bad++; $display("FAIL rmid_streamb got %0b want 0", streamb); end
    n_cmp++; if (cfar_thresh !== 16'd0) begin n_bad++; $display("FAIL rmid_thresh got %0d want 0", cfar_thresh); end
    n_cmp++; if (stat_cfar !== 16'd0) begin n_bad++; $display("FAIL rmid_stat got %0d want 0", stat_cfar); end
    tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (cfar_thresh !== 16'd0) begin n_bad++; $display("FAIL rmid_idle_thresh got %0d want 0", cfar_thresh); end
    thresh_manual = 16'd77;
    cfar_en = 1'b1;
    tick();
    n_cmp++; if (cfar_thresh !== 16'd77) begin n_bad++; $display("FAIL rmid_seed got %0d want 77", cfar_thresh); end
    for (int i = 0; i < WIN - 1; i++) send_event(16'd200);
    tick();
    n_cmp++; if (cfar_update !== 1'b0) begin n_bad++; $display("FAIL rmid_no_early got %0b want 0", cfar_update); end
    send_event(16'd200);
    tick();
    n_cmp++; if (cfar_update !== 1'b1) begin n_bad++; $display("FAIL rmid_pulse got %0b want 1", cfar_update); end
    n_cmp++; if (stat_cfar !== 16'd8) begin n_bad++; $display("FAIL rmid_stat8 got %0d want 8", stat_cfar); end
    n_cmp++; if (cfar_thresh !== 16'd82) begin n_bad++; $display("FAIL rmid_thresh82 got %0d want 82", cfar_thresh); end
  endtask

  initial begin
    test_reset();
`ifdef NV_INTEG_EN
    test_integ();
`endif
    test_manual();
    test_cfar_up();
    test_saturation();
    test_equal();
`ifndef NV_INTEG_EN
    test_back_to_back();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
